// File: rtl/cpu_debug_pkg.sv
// Shared types for the OCI RAM arbiter: FSM states, jdo field positions, JTAG op encoding.
package cpu_debug_pkg;

  typedef enum logic [1:0] {IDLE, JT_RD, AV_RD} state_t;

  localparam int JDO_W         = 38;
  localparam int JDO_WR_BIT    = 35;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_LSB  = 17;

  // JOP_RD post-increments jptr, JOP_REREAD does not
  typedef enum logic [1:0] {
    JOP_RD     = 2'd0,
    JOP_REREAD = 2'd1,
    JOP_WR     = 2'd2
  } jop_t;

  typedef struct packed {
    jop_t        op;
    logic [31:0] wdata;
  } jcmd_t;

endpackage

// File: rtl/cpu_debug_jtag_cmd_buf.sv
// One-deep JTAG op buffer plus auto-incrementing jptr; accepts a new op in the cycle the old one pops.
// A pulse arriving while full (and not popping) is dropped and sets sticky jtag_overrun.
module cpu_debug_jtag_cmd_buf
  import cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              pop,
  input  logic              inc,
  output logic              pend_vld,
  output jcmd_t             pend,
  output logic [ADDR_W-1:0] jptr,
  output logic              jtag_overrun
);

  logic  push;
  jcmd_t cmd_in;
  logic  jdo_unused;

  assign jdo_unused = ^{jdo[JDO_W-1:JDO_WR_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

  always_comb begin
    push         = take_action_ocimem_b | take_no_action_ocimem_a;
    cmd_in.wdata = jdo[JDO_WDATA_LSB +: 32];
    cmd_in.op    = JOP_REREAD;
    if (take_action_ocimem_b) begin
      cmd_in.op = jdo[JDO_WR_BIT] ? JOP_WR : JOP_RD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld     <= 1'b0;
      pend         <= '0;
      jptr         <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      if (push && pend_vld && !pop) begin
        jtag_overrun <= 1'b1;
      end
      if (push && (!pend_vld || pop)) begin
        pend_vld <= 1'b1;
        pend     <= cmd_in;
      end else if (pop) begin
        pend_vld <= 1'b0;
      end
      // An explicit pointer load beats a same-cycle post-increment
      if (take_action_ocimem_a) begin
        jptr <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if (inc) begin
        jptr <= jptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_debug_ocimem_arbiter.sv
// Shares the single-port OCI RAM between JTAG and Avalon: writes 1 cycle, reads 2, alternating tie priority.
// Avalon is held with av_waitrequest; optional write protection is enabled by OCIMEM_WP_EN.
module cpu_debug_ocimem_arbiter
  import cpu_debug_pkg::*;
#(
  parameter int               ADDR_W  = 8,
  parameter int               DATA_W  = 32,
  parameter logic [ADDR_W-1:0] WP_BASE = 8'hE0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
`ifdef OCIMEM_WP_EN
  input  logic              wp_en,
  output logic              wp_violation,
`endif
  output logic              jtag_overrun
);

  state_t            state, state_nxt;
  logic              pend_vld, pop, inc;
  jcmd_t             pend;
  logic [ADDR_W-1:0] jptr;
  logic              jtag_lost, av_rd_done;
  logic              av_req, grant_j, grant_av, contested, wp_hit;

  cpu_debug_jtag_cmd_buf #(.ADDR_W(ADDR_W)) u_cmd_buf (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .pop                     (pop),
    .inc                     (inc),
    .pend_vld                (pend_vld),
    .pend                    (pend),
    .jptr                    (jptr),
    .jtag_overrun            (jtag_overrun)
  );

`ifdef OCIMEM_WP_EN
  assign wp_hit = wp_en && (av_address >= WP_BASE);
`else
  logic wp_base_unused;
  assign wp_base_unused = ^WP_BASE;
  assign wp_hit = 1'b0;
`endif

  assign av_req        = av_read | av_write;
  assign monitor_ready = !pend_vld && (state != JT_RD);

  always_comb begin
    state_nxt      = state;
    ram_rd         = 1'b0;
    ram_wr         = 1'b0;
    ram_addr       = '0;
    ram_wdata      = '0;
    ram_be         = 4'h0;
    av_waitrequest = !av_rd_done;
    pop            = 1'b0;
    inc            = 1'b0;
    grant_j        = 1'b0;
    grant_av       = 1'b0;
    contested      = 1'b0;
    case (state)
      IDLE: begin
        // The Avalon read-completion cycle issues no grant
        if (!av_rd_done) begin
          contested = pend_vld && av_req;
          if (pend_vld && (!av_req || jtag_lost)) begin
            grant_j = 1'b1;
          end else if (av_req) begin
            grant_av = 1'b1;
          end
          if (grant_j) begin
            ram_addr = jptr;
            if (pend.op == JOP_WR) begin
              ram_wr    = 1'b1;
              ram_be    = 4'hF;
              ram_wdata = pend.wdata;
              pop       = 1'b1;
              inc       = 1'b1;
            end else begin
              ram_rd    = 1'b1;
              state_nxt = JT_RD;
            end
          end else if (grant_av) begin
            ram_addr = av_address;
            if (av_write) begin
              ram_wr         = !wp_hit;
              ram_be         = av_byteenable;
              ram_wdata      = av_writedata;
              av_waitrequest = 1'b0;
            end else begin
              ram_rd    = 1'b1;
              state_nxt = AV_RD;
            end
          end
        end
      end
      JT_RD: begin
        pop       = 1'b1;
        inc       = (pend.op == JOP_RD);
        state_nxt = IDLE;
      end
      AV_RD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      jtag_lost   <= 1'b1;
      av_rd_done  <= 1'b0;
      av_readdata <= '0;
      MonDReg     <= '0;
    end else begin
      state      <= state_nxt;
      av_rd_done <= (state == AV_RD);
      if (contested) begin
        jtag_lost <= grant_av;
      end
      if (state == AV_RD) begin
        av_readdata <= ram_rdata;
      end
      if (state == JT_RD) begin
        MonDReg <= ram_rdata;
      end
    end
  end

`ifdef OCIMEM_WP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_violation <= 1'b0;
    end else if (grant_av && av_write && wp_hit) begin
      wp_violation <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Scoreboard bench for cpu_debug_ocimem_arbiter: expected RAM accesses and Avalon read data are queued
// by the stimulus and checked by a negedge monitor; OCIMEM_WP_EN cases build only when defined.
module tb_cpu_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_rd, ram_wr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, jtag_overrun;
`ifdef OCIMEM_WP_EN
  logic        wp_en, wp_violation;
`endif

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] av_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  cpu_debug_ocimem_arbiter dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .ram_addr                (ram_addr),
    .ram_rd                  (ram_rd),
    .ram_wr                  (ram_wr),
    .ram_wdata               (ram_wdata),
    .ram_be                  (ram_be),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
`ifdef OCIMEM_WP_EN
    .wp_en                   (wp_en),
    .wp_violation            (wp_violation),
`endif
    .jtag_overrun            (jtag_overrun)
  );

  // Single-port RAM model with byte enables and 1-cycle read latency
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  // Monitor: every RAM strobe and every Avalon read completion pops its queue
  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_rd || ram_wr) begin
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL ram_access unexpected wr=%0d addr=%h data=%h", ram_wr, ram_addr, ram_wdata);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          if (ram_wr !== e.wr || ram_addr !== e.addr ||
              (e.wr && (ram_wdata !== e.data || ram_be !== e.be))) begin
            errors++;
            $display("FAIL ram_access got wr=%0d addr=%h data=%h be=%h exp wr=%0d addr=%h data=%h be=%h",
                     ram_wr, ram_addr, ram_wdata, ram_be, e.wr, e.addr, e.data, e.be);
          end
        end
      end
      if (av_read && !av_waitrequest) begin
        checks++;
        if (av_q.size() == 0) begin
          errors++;
          $display("FAIL av_readdata unexpected completion data=%h", av_readdata);
        end else begin
          logic [31:0] d;
          d = av_q.pop_front();
          if (av_readdata !== d) begin
            errors++;
            $display("FAIL av_readdata got=%h exp=%h", av_readdata, d);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic exp_acc(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    acc_t e;
    e.wr = wr; e.addr = a; e.data = d; e.be = be;
    acc_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jt_a(input logic [7:0] a);
    jdo = {13'b0, a, 17'b0};
    take_action_ocimem_a = 1'b1;
    step(1);
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jt_wr(input logic [31:0] d);
    jdo = {2'b00, 1'b1, d, 3'b000};
    take_action_ocimem_b = 1'b1;
    step(1);
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic jt_rd();
    jdo = 38'b0;
    take_action_ocimem_b = 1'b1;
    step(1);
    take_action_ocimem_b = 1'b0;
  endtask

  // lat counts negedges from strobe assertion to completion (1 = same cycle)
  task automatic av_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be, input int lat);
    int  n;
    bit  done;
    n = 0; done = 0;
    if (!wr) av_q.push_back(d);
    av_address = a; av_writedata = wr ? d : 32'h0; av_byteenable = be;
    av_read = !wr; av_write = wr;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      n++;
      if (!av_waitrequest) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL av_timeout got=stalled exp=completion addr=%h", a);
    end else begin
      chk(wr ? "av_wr_latency" : "av_rd_latency", n, lat);
    end
    step(1);
    av_read = 1'b0; av_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    jdo = 38'b0;
    take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    av_address = 8'h0; av_read = 0; av_write = 0; av_writedata = 32'h0; av_byteenable = 4'h0;
`ifdef OCIMEM_WP_EN
    wp_en = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_waitrequest", av_waitrequest, 1);
    chk("rst_readdata", av_readdata, 0);
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ram_be", ram_be, 0);
    chk("rst_mondreg", MonDReg, 0);
    chk("rst_monitor_ready", monitor_ready, 1);
    chk("rst_overrun", jtag_overrun, 0);
    step(1);
    reset_n = 1'b1;
    step(1);

    // JTAG pointer load then two writes: second lands at the incremented pointer
    exp_acc(1, 8'h10, 32'hDEADBEEF, 4'hF);
    exp_acc(1, 8'h11, 32'h11111111, 4'hF);
    jt_a(8'h10);
    jt_wr(32'hDEADBEEF);
    jt_wr(32'h11111111);
    step(4);

    // JTAG read: MonDReg updates 2 cycles after the grant, pointer increments
    jt_a(8'h10);
    exp_acc(0, 8'h10, 32'h0, 4'h0);
    jt_rd();
    @(negedge clk); chk("jt_rd_busy_ready", monitor_ready, 0);
    step(1);
    @(negedge clk); chk("jt_rd_mondreg_early", MonDReg, 32'h0);
    step(1);
    @(negedge clk); chk("jt_rd_mondreg", MonDReg, 32'hDEADBEEF);
    chk("jt_rd_ready_back", monitor_ready, 1);
    step(1);
    exp_acc(1, 8'h11, 32'h22222222, 4'hF);
    jt_wr(32'h22222222);
    step(3);

    // Pointer wrap 0xFF -> 0x00
    exp_acc(1, 8'hFF, 32'hA5A5A5A5, 4'hF);
    exp_acc(1, 8'h00, 32'h5A5A5A5A, 4'hF);
    jt_a(8'hFF);
    jt_wr(32'hA5A5A5A5);
    jt_wr(32'h5A5A5A5A);
    step(3);

    // First tie: JTAG wins, Avalon follows
    jt_a(8'h11);
    exp_acc(0, 8'h11, 32'h0, 4'h0);
    exp_acc(0, 8'h10, 32'h0, 4'h0);
    fork
      jt_rd();
      begin step(1); av_xfer(0, 8'h10, 32'hDEADBEEF, 4'hF, 5); end
    join
    step(2);
    chk("tie1_mondreg", MonDReg, 32'h22222222);

    // Second tie: Avalon wins, JTAG follows
    jt_a(8'hFF);
    exp_acc(0, 8'h00, 32'h0, 4'h0);
    exp_acc(0, 8'hFF, 32'h0, 4'h0);
    fork
      jt_rd();
      begin step(1); av_xfer(0, 8'h00, 32'h5A5A5A5A, 4'hF, 3); end
    join
    step(3);
    chk("tie2_mondreg", MonDReg, 32'hA5A5A5A5);

    // Three back-to-back JTAG writes against an Avalon read: third is dropped
    chk("pre_overrun", jtag_overrun, 0);
    jt_a(8'h30);
    exp_acc(1, 8'h30, 32'h00000301, 4'hF);
    exp_acc(0, 8'h10, 32'h0, 4'h0);
    exp_acc(1, 8'h31, 32'h00000302, 4'hF);
    fork
      begin jt_wr(32'h00000301); jt_wr(32'h00000302); jt_wr(32'h00000303); end
      begin step(1); av_xfer(0, 8'h10, 32'hDEADBEEF, 4'hF, 4); end
    join
    step(3);
    chk("overrun_set", jtag_overrun, 1);
    exp_acc(1, 8'h32, 32'h00000304, 4'hF);
    jt_wr(32'h00000304);
    step(3);

    // Avalon partial-byte write, then read back
    exp_acc(1, 8'h40, 32'h12345678, 4'h5);
    av_xfer(1, 8'h40, 32'h12345678, 4'h5, 1);
    exp_acc(0, 8'h40, 32'h0, 4'h0);
    av_xfer(0, 8'h40, 32'h00340078, 4'hF, 3);
    step(2);

`ifdef OCIMEM_WP_EN
    // Protected Avalon write completes without touching RAM; JTAG write is unprotected
    wp_en = 1'b1;
    chk("wp_violation_clear", wp_violation, 0);
    av_xfer(1, 8'hE4, 32'hBADBAD00, 4'hF, 1);
    chk("wp_violation_set", wp_violation, 1);
    jt_a(8'hE4);
    exp_acc(1, 8'hE4, 32'hCAFEF00D, 4'hF);
    jt_wr(32'hCAFEF00D);
    step(3);
    exp_acc(0, 8'hE4, 32'h0, 4'h0);
    av_xfer(0, 8'hE4, 32'hCAFEF00D, 4'hF, 3);
    step(2);
`endif

    step(5);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("av_q_drained", av_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_debug_ocimem_arbiter.md
Name: cpu_debug_ocimem_arbiter

Overview:
- Sysclk-domain controller that shares the single-port on-chip debug memory (OCI RAM) between two requesters.
- Requester 1: JTAG debug actions decoded by the debug slave (take_action_ocimem_a/b, take_no_action_ocimem_a with jdo).
- Requester 2: the CPU's Avalon debug-memory slave port.
- Sequences RAM accesses, owns the JTAG auto-incrementing address pointer and MonDReg, and arbitrates with alternating priority.

Parameters:
- ADDR_W, 8, OCI RAM word-address width (256 words).
- DATA_W, 32, data width; jdo and MonDReg field mapping is defined only for 32.
- WP_BASE, 8'hE0, first write-protected word address (used only with OCIMEM_WP_EN).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  JTAG data, already synchronised to clk.
- take_action_ocimem_a  in  1  one-cycle pulse: load pointer, jptr <= jdo[ADDR_W+16:17].
- take_action_ocimem_b  in  1  one-cycle pulse: jdo[35]=1 writes jdo[34:3]; jdo[35]=0 reads. Post-increments jptr in both cases.
- take_no_action_ocimem_a  in  1  one-cycle pulse: re-read at jptr into MonDReg, no increment.
- av_address  in  ADDR_W  Avalon word address.
- av_read / av_write  in  1  Avalon strobes; mutually exclusive.
- av_writedata  in  32  Avalon write data.
- av_byteenable  in  4  Avalon byte enables.
- av_readdata  out  32  Avalon read data.
- av_waitrequest  out  1  Avalon stall.
- ram_addr  out  ADDR_W  RAM address.
- ram_rd / ram_wr  out  1  RAM strobes.
- ram_wdata  out  32  RAM write data.
- ram_be  out  4  RAM byte enables.
- ram_rdata  in  32  RAM read data, valid exactly 1 cycle after ram_rd.
- MonDReg  out  32  JTAG monitor data register.
- monitor_ready  out  1  high when no JTAG op is pending or in flight.
- jtag_overrun  out  1  sticky; set when a JTAG pulse is dropped.

Behaviour:
Reset (async, reset_n=0):
- State IDLE; jptr=0; MonDReg=0.
- av_waitrequest=1; av_readdata=0.
- ram_rd=ram_wr=0; ram_addr=0; ram_wdata=0; ram_be=0.
- monitor_ready=1; jtag_overrun=0.
- Reset mid-access aborts the access with no write; the Avalon master must reissue.

JTAG pending buffer (1 deep):
- take_action_ocimem_a updates jptr immediately. It needs no RAM access and is never dropped.
- take_action_ocimem_b and take_no_action_ocimem_a are captured as {op, wdata}.
- A pulse that arrives while the buffer is full is dropped and sets jtag_overrun. It is cleared only by reset.
- An ocimem_a pulse in the same cycle as a buffered op loads jptr first; the buffered op later uses the new jptr.

FSM states IDLE, JT_RD, AV_RD:
- IDLE grant rules:
  - JTAG only -> grant JTAG.
  - Avalon only -> grant Avalon.
  - Both -> grant whichever did not win the previous contested grant (last_grant flag, reset value JTAG-lost, so JTAG wins the first tie).
- JTAG write: ram_wr=1, ram_be=4'hF, addr=jptr; jptr++ (wraps 2^ADDR_W-1 -> 0); stay IDLE. Buffer frees that cycle.
- JTAG read: ram_rd=1, go JT_RD. In JT_RD: MonDReg <= ram_rdata, jptr++ if op was ocimem_b, buffer frees, return IDLE.
- Avalon write: ram_wr=1 with av_byteenable; av_waitrequest=0 that same cycle; stay IDLE.
- Avalon read: ram_rd=1, go AV_RD. In AV_RD: av_readdata <= ram_rdata and av_waitrequest=0 in the next cycle. No new grant is issued while the read completes.
- av_waitrequest is 1 in all other cycles, including idle.
- Throughput: writes take 1 cycle; reads take 2 cycles from grant to completion.
- monitor_ready = buffer empty AND state != JT_RD.

Optional Feature:
- Macro OCIMEM_WP_EN. When defined:
  - Adds input wp_en (1) and output wp_violation (1, sticky, reset 0).
  - An Avalon write with wp_en=1 and av_address >= WP_BASE completes normally (waitrequest low one cycle) but ram_wr stays 0, and wp_violation sets.
  - JTAG writes are never protected.
- Undefined: ports absent; all Avalon writes proceed.

Decomposition:
- Shared package cpu_debug_pkg holds:
  - state enum {IDLE, JT_RD, AV_RD};
  - jdo field constants: JDO_WR_BIT=35, JDO_WDATA_LSB=3, JDO_ADDR_LSB=17;
  - the JTAG op encoding.
- One sub-module: cpu_debug_jtag_cmd_buf, holding the 1-deep pending buffer, jptr and overrun logic.

Test Plan:
- ocimem_a with jdo addr 0x10; then ocimem_b write of 0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, jptr=0x11.
- ocimem_a to 0x10; then ocimem_b read -> MonDReg=0xDEADBEEF 2 cycles after the grant, jptr=0x11, monitor_ready returns to 1.
- jptr=0xFF; JTAG write -> jptr wraps to 0x00.
- Avalon read and JTAG read pending in the same cycle:
  - JTAG granted first; Avalon completes in the next IDLE.
  - Repeat -> Avalon wins the second tie.
- Three ocimem_b pulses on consecutive cycles while an Avalon read is in flight -> first serviced, second buffered, third dropped; jtag_overrun=1.
- With OCIMEM_WP_EN and wp_en=1: Avalon write to 0xE4 -> no ram_wr, wp_violation=1. A JTAG write to 0xE4 succeeds.
